// File: rtl/fpu_seq_unit_if.sv
// Request/response bundle for fpu_seq_unit: operation issue side and result
// delivery side, each with its own valid/ready handshake.
interface fpu_seq_unit_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         flush_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [5:0]   op_i;
   logic [W-1:0] opa_i;
   logic [W-1:0] opb_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [W-1:0] result_o;
   logic         invalid_o;
   logic         illegal_o;
   logic         busy_o;

   modport slave (
      input  flush_i, in_valid_i, op_i, opa_i, opb_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, invalid_o, illegal_o, busy_o
   );

   modport master (
      output flush_i, in_valid_i, op_i, opa_i, opb_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, invalid_o, illegal_o, busy_o
   );
endinterface

// File: rtl/fpu_seq_unit.sv
// Sign/compare/min-max FP unit: fixed-latency valid-tagged pipeline feeding an
// in-order result FIFO, with credit-based input flow control and flush.
module fpu_seq_unit #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 23,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input logic           Clk,
   input logic           Reset,
   fpu_seq_unit_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [5:0] OP_FLT  = 6'b011001;
   localparam logic [5:0] OP_FABS = 6'b011010;
   localparam logic [5:0] OP_FEQ  = 6'b011011;
   localparam logic [5:0] OP_FMIN = 6'b011100;
   localparam logic [5:0] OP_FMAX = 6'b011101;
   localparam logic [5:0] OP_FNEG = 6'b011110;
   localparam logic [5:0] OP_FLE  = 6'b011111;

   localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic [W-1:0] res;
      logic         invalid;
      logic         illegal;
   } entry_t;

   logic             flush;
   logic [W-1:0]     opa;
   logic [W-1:0]     opb;
   logic             sign_a;
   logic             sign_b;
   logic [EXP_W-1:0] exp_a;
   logic [EXP_W-1:0] exp_b;
   logic [MAN_W-1:0] man_a;
   logic [MAN_W-1:0] man_b;
   logic [W-2:0]     mag_a;
   logic [W-2:0]     mag_b;
   logic             nan_a;
   logic             nan_b;
   logic             zeros;
   logic             lt;
   logic             eq;
   entry_t           new_e;

   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             pop;
   logic             wr_en;
   entry_t           wr_e;

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    used;
   entry_t           mem [DEPTH];
   entry_t           head;

   assign flush  = bus.flush_i;
   assign opa    = bus.opa_i;
   assign opb    = bus.opb_i;
   assign sign_a = opa[W-1];
   assign sign_b = opb[W-1];
   assign exp_a  = opa[W-2:MAN_W];
   assign exp_b  = opb[W-2:MAN_W];
   assign man_a  = opa[MAN_W-1:0];
   assign man_b  = opb[MAN_W-1:0];
   assign mag_a  = opa[W-2:0];
   assign mag_b  = opb[W-2:0];
   assign nan_a  = (&exp_a) & (|man_a);
   assign nan_b  = (&exp_b) & (|man_b);
   assign zeros  = ~(|mag_a) & ~(|mag_b);

   // Ordering ignores NaN; callers screen NaN operands first.
   always_comb begin
      eq = (opa == opb) | zeros;
      lt = 1'b0;
      if (sign_a != sign_b)
         lt = sign_a & ~zeros;
      else if (sign_a)
         lt = mag_a > mag_b;
      else
         lt = mag_a < mag_b;
   end

   always_comb begin
      new_e = '0;
      case (bus.op_i)
         OP_FABS: new_e.res = {1'b0, mag_a};
         OP_FNEG: new_e.res = {~sign_a, mag_a};
         OP_FLT, OP_FEQ, OP_FLE: begin
            if (nan_a | nan_b)
               new_e.invalid = 1'b1;
            else if (bus.op_i == OP_FLT)
               new_e.res = {{(W-1){1'b0}}, lt};
            else if (bus.op_i == OP_FEQ)
               new_e.res = {{(W-1){1'b0}}, eq};
            else
               new_e.res = {{(W-1){1'b0}}, lt | eq};
         end
         OP_FMIN, OP_FMAX: begin
            if (nan_a & nan_b)
               new_e.res = CANON_NAN;
            else if (nan_a)
               new_e.res = opb;
            else if (nan_b)
               new_e.res = opa;
            else if (zeros)
               // signed zeros compare equal, so pick by sign bit
               new_e.res = ((bus.op_i == OP_FMIN) == sign_a) ? opa : opb;
            else
               new_e.res = ((bus.op_i == OP_FMIN) == lt) ? opa : opb;
         end
         default: new_e.illegal = 1'b1;
      endcase
   end

   assign in_ready  = Reset & (used < DEPTH_C);
   assign out_valid = (count != '0);
   assign accept    = bus.in_valid_i & in_ready & ~flush;
   assign pop       = out_valid & bus.out_ready_i & ~flush;

   // The FIFO write is the final latency stage, so only LATENCY-1 registers precede it.
   if (LATENCY == 1) begin : g_direct
      assign wr_en = accept;
      assign wr_e  = new_e;
   end else begin : g_pipe
      logic [LATENCY-2:0] vld;
      entry_t             dat [LATENCY-1];

      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            vld <= '0;
         end else if (flush) begin
            vld <= '0;
         end else begin
            vld[0] <= accept;
            for (int unsigned i = 1; i < LATENCY - 1; i++)
               vld[i] <= vld[i-1];
         end
      end

      always_ff @(posedge Clk) begin
         dat[0] <= new_e;
         for (int unsigned i = 1; i < LATENCY - 1; i++)
            dat[i] <= dat[i-1];
      end

      assign wr_en = vld[LATENCY-2];
      assign wr_e  = dat[LATENCY-2];
   end

   // used counts every slot held (in flight plus queued) and gates acceptance.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         used   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         used   <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(pop);
         used  <= used + CW'(accept) - CW'(pop);
      end
   end

   always_ff @(posedge Clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_e;
   end

   assign head = mem[rd_ptr];

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.result_o    = out_valid ? head.res : '0;
   assign bus.invalid_o   = out_valid & head.invalid;
   assign bus.illegal_o   = out_valid & head.illegal;
   assign bus.busy_o      = (used != '0);
endmodule

// File: tb/tb_fpu_seq_unit.sv
// Directed plus randomized bench for fpu_seq_unit, checked against an
// integer-key ordering model and an in-order expected-result queue.
module tb_fpu_seq_unit;
   localparam int EW  = 8;
   localparam int MW  = 23;
   localparam int LAT = 2;
   localparam int DEP = 4;

   localparam logic [5:0] FLT  = 6'b011001;
   localparam logic [5:0] FABS = 6'b011010;
   localparam logic [5:0] FEQ  = 6'b011011;
   localparam logic [5:0] FMIN = 6'b011100;
   localparam logic [5:0] FMAX = 6'b011101;
   localparam logic [5:0] FNEG = 6'b011110;
   localparam logic [5:0] FLE  = 6'b011111;

   typedef struct {
      logic [31:0] res;
      logic        inv;
      logic        ill;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          total = 0;
   int          bad   = 0;
   int          accepted;
   logic        last_acc;
   exp_t        sb[$];
   logic [31:0] specials [10] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                  32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFFC00001,
                                  32'h7F800001, 32'h00000001};

   fpu_seq_unit_if #(.EXP_W(EW), .MAN_W(MW)) bus ();

   fpu_seq_unit #(.EXP_W(EW), .MAN_W(MW), .LATENCY(LAT), .DEPTH(DEP)) dut (
      .Clk  (clk),
      .Reset(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      chk(tag, {31'b0, obs}, {31'b0, exp});
   endtask

   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Total order over non-NaN values as a signed integer; both zeros map to 0.
   function automatic longint key(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint ka;
      longint kb;
      logic   r;
      ka = key(a);
      kb = key(b);
      e  = '{res: 32'h0, inv: 1'b0, ill: 1'b0};
      case (op)
         FABS: e.res = a & 32'h7FFFFFFF;
         FNEG: e.res = a ^ 32'h80000000;
         FLT, FEQ, FLE: begin
            if (is_nan(a) || is_nan(b)) begin
               e.inv = 1'b1;
            end else begin
               r = (op == FLT) ? (ka < kb) : (op == FEQ) ? (ka == kb) : (ka <= kb);
               e.res = {31'b0, r};
            end
         end
         FMIN, FMAX: begin
            if (is_nan(a) && is_nan(b))
               e.res = 32'h7FC00000;
            else if (is_nan(a))
               e.res = b;
            else if (is_nan(b))
               e.res = a;
            else if (ka == 0 && kb == 0)
               e.res = (op == FMIN) ? ((a[31] | b[31]) ? 32'h80000000 : 32'h0)
                                    : ((a[31] & b[31]) ? 32'h80000000 : 32'h0);
            else
               e.res = ((ka < kb) == (op == FMIN)) ? a : b;
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic [5:0] rnd_op();
      if ($urandom_range(0, 9) == 0)
         return 6'($urandom);
      return FLT + 6'($urandom_range(0, 6));
   endfunction

   function automatic logic [31:0] rnd_fp();
      if ($urandom_range(0, 1) == 0)
         return specials[$urandom_range(0, 9)];
      return $urandom;
   endfunction

   // One clock: drive at the falling edge, predict accept/pop, return at the next falling edge.
   task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
      exp_t e;
      bus.in_valid_i  = v;
      bus.op_i        = op;
      bus.opa_i       = a;
      bus.opb_i       = b;
      bus.out_ready_i = ordy;
      bus.flush_i     = fl;
      #1;
      last_acc = v && bus.in_ready_o && !fl;
      if (bus.out_valid_o && ordy && !fl) begin
         if (sb.size() == 0) begin
            chkb("spurious_out", bus.out_valid_o, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("sb_result", bus.result_o, e.res);
            chkb("sb_invalid", bus.invalid_o, e.inv);
            chkb("sb_illegal", bus.illegal_o, e.ill);
         end
      end
      if (fl)
         sb.delete();
      if (last_acc)
         sb.push_back(model(op, a, b));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 6'b000000, 32'h0, 32'h0, ordy, 1'b0);
   endtask

   task automatic single(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] x_res, input logic x_inv, input logic x_ill);
      bit seen;
      seen = 1'b0;
      step(1'b1, op, a, b, 1'b1, 1'b0);
      for (int n = 0; n < 12 && !seen; n++) begin
         if (bus.out_valid_o) begin
            seen = 1'b1;
            chk({tag, "_res"}, bus.result_o, x_res);
            chkb({tag, "_inv"}, bus.invalid_o, x_inv);
            chkb({tag, "_ill"}, bus.illegal_o, x_ill);
         end
         idle(1'b1);
      end
      if (!seen)
         chkb({tag, "_timeout"}, bus.out_valid_o, 1'b1);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.op_i = 6'b0;
      bus.opa_i = 32'h0; bus.opb_i = 32'h0; bus.out_ready_i = 1'b0;

      repeat (2) @(negedge clk);
      chkb("rst_in_ready", bus.in_ready_o, 1'b0);
      chkb("rst_out_valid", bus.out_valid_o, 1'b0);
      chkb("rst_busy", bus.busy_o, 1'b0);
      chk("rst_result", bus.result_o, 32'h0);
      chkb("rst_invalid", bus.invalid_o, 1'b0);
      chkb("rst_illegal", bus.illegal_o, 1'b0);
      rst_n = 1'b1;
      #1;
      chkb("ready_after_reset", bus.in_ready_o, 1'b1);
      @(negedge clk);

      // FLT -1 < 1 with latency observation
      step(1'b1, FLT, 32'hBF800000, 32'h3F800000, 1'b1, 1'b0);
      chkb("flt_accept", last_acc, 1'b1);
      chkb("flt_early", bus.out_valid_o, 1'b0);
      chkb("flt_busy", bus.busy_o, 1'b1);
      idle(1'b1);
      chkb("flt_on_time", bus.out_valid_o, 1'b1);
      chk("flt_res", bus.result_o, 32'h00000001);
      chkb("flt_inv", bus.invalid_o, 1'b0);
      idle(1'b1);
      chkb("flt_idle_busy", bus.busy_o, 1'b0);

      single("fabs", FABS, 32'hC0490FDB, 32'h0, 32'h40490FDB, 1'b0, 1'b0);
      single("fneg", FNEG, 32'hC0490FDB, 32'h0, 32'h40490FDB, 1'b0, 1'b0);
      single("feq_zero", FEQ, 32'h00000000, 32'h80000000, 32'h1, 1'b0, 1'b0);
      single("flt_nan", FLT, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1, 1'b0);
      single("fmax_nan", FMAX, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
      single("fmin_zero", FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
      single("fmax_zero", FMAX, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
      single("fmin_2nan", FMIN, 32'h7FC00001, 32'hFF800001, 32'h7FC00000, 1'b0, 1'b0);
      single("fle_zero", FLE, 32'h80000000, 32'h00000000, 32'h1, 1'b0, 1'b0);
      single("flt_neg", FLT, 32'hC0000000, 32'hBF800000, 32'h1, 1'b0, 1'b0);
      single("illegal", 6'b000000, 32'h3F800000, 32'h3F800000, 32'h0, 1'b0, 1'b1);

      // backpressure: six requests against four slots
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, rnd_op(), rnd_fp(), rnd_fp(), 1'b0, 1'b0);
         if (last_acc) accepted++;
      end
      chk("bp_accepts", 32'(accepted), 32'd4);
      chkb("bp_ready_low", bus.in_ready_o, 1'b0);
      chkb("bp_out_valid", bus.out_valid_o, 1'b1);
      chk("bp_head", bus.result_o, sb[0].res);
      idle(1'b0);
      chk("bp_hold", bus.result_o, sb[0].res);
      chkb("bp_ready_still_low", bus.in_ready_o, 1'b0);
      idle(1'b1);
      chkb("bp_ready_after_pop", bus.in_ready_o, 1'b1);
      repeat (3) idle(1'b1);
      chkb("bp_drained", bus.out_valid_o, 1'b0);
      chkb("bp_idle", bus.busy_o, 1'b0);

      // flush with three queued and a same-cycle accept
      repeat (3) step(1'b1, rnd_op(), rnd_fp(), rnd_fp(), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      chkb("fl_busy_before", bus.busy_o, 1'b1);
      step(1'b1, FABS, 32'hBF800000, 32'h0, 1'b1, 1'b1);
      chkb("fl_out_valid", bus.out_valid_o, 1'b0);
      chkb("fl_busy", bus.busy_o, 1'b0);
      chkb("fl_ready", bus.in_ready_o, 1'b1);
      repeat (4) idle(1'b1);
      chkb("fl_no_late_result", bus.out_valid_o, 1'b0);

      // reset while an operation is in flight
      step(1'b1, FEQ, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chkb("mid_rst_ready", bus.in_ready_o, 1'b0);
      chkb("mid_rst_busy", bus.busy_o, 1'b0);
      chkb("mid_rst_valid", bus.out_valid_o, 1'b0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) idle(1'b1);
      chkb("mid_rst_no_result", bus.out_valid_o, 1'b0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         chkb("rnd_busy", bus.busy_o, sb.size() != 0);
         chkb("rnd_ready", bus.in_ready_o, sb.size() < DEP);
         if (bus.out_valid_o && sb.size() != 0)
            chk("rnd_head", bus.result_o, sb[0].res);
         a = rnd_fp();
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h1;
            default: b = rnd_fp();
         endcase
         step($urandom_range(0, 2) != 0, rnd_op(), a, b,
              $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      end
      for (int n = 0; n < 20 && sb.size() != 0; n++)
         idle(1'b1);
      chkb("final_busy", bus.busy_o, 1'b0);
      chkb("final_valid", bus.out_valid_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fpu_seq_unit.md
FPU_SEQ_UNIT -- requirements
Module: fpu_seq_unit

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent width.
REQ-002 SHALL have parameter MAN_W, default 23: mantissa width; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..8: accept-to-earliest-result cycles.
REQ-004 SHALL have parameter DEPTH, default 4, legal range 2..16, power of two: total result slots, in-flight plus queued.
REQ-005 SHALL have port Clk, input, 1: clock, rising edge.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1: synchronous discard of all in-flight and queued results.
REQ-008 SHALL have port in_valid_i, input, 1: operation request.
REQ-009 SHALL have port in_ready_o, output, 1: request may be accepted this cycle.
REQ-010 SHALL have port op_i, input, 6: opcode.
REQ-011 SHALL have ports opa_i and opb_i, input, W each: operands.
REQ-012 SHALL have port out_valid_o, output, 1: result_o and flags are valid.
REQ-013 SHALL have port out_ready_i, input, 1: consumer takes result.
REQ-014 SHALL have port result_o, output, W: result.
REQ-015 SHALL have port invalid_o, output, 1: NaN operand seen by a compare.
REQ-016 SHALL have port illegal_o, output, 1: unsupported opcode.
REQ-017 SHALL have port busy_o, output, 1: any operation in flight or queued.

Function
REQ-018 SHALL accept an operation at a rising edge where in_valid_i=1, in_ready_o=1 and flush_i=0.
REQ-019 SHALL implement these opcodes: 011001 FLT, 011010 FABS, 011011 FEQ, 011100 FMIN, 011101 FMAX, 011110 FNEG, 011111 FLE.
REQ-020 SHALL compute FABS as {0, opa[W-2:0]} and FNEG as {~opa[W-1], opa[W-2:0]}, NaN payload untouched, invalid_o=0.
REQ-021 SHALL return FLT/FEQ/FLE results as W-bit 1 or 0, using full IEEE ordering: sign, then exponent, then mantissa, with magnitude order reversed for negatives.
REQ-022 SHALL treat +0 and -0 as equal: FEQ=1, FLE=1, FLT=0.
REQ-023 SHALL return 0 with invalid_o=1 for FLT/FEQ/FLE when either operand is NaN (exponent all ones, mantissa nonzero).
REQ-024 SHALL return the non-NaN operand for FMIN/FMAX when exactly one operand is NaN; canonical NaN {0, all-ones exponent, 1, zeros} when both are NaN; invalid_o=0.
REQ-025 SHALL return -0 for FMIN and +0 for FMAX on {+0, -0} operands.
REQ-026 SHALL produce result 0 with illegal_o=1 for any other opcode, occupying a slot like a legal operation.
REQ-027 SHALL hold each accepted operation's result and flags in a LATENCY-deep valid-tagged pipeline, then in an in-order FIFO.
REQ-028 SHALL deliver results strictly in acceptance order.
REQ-029 SHALL make a result accepted at edge t visible (out_valid_o=1) no earlier than the cycle following edge t+LATENCY-1, and exactly then when the FIFO is empty.
REQ-030 SHALL sustain one accept per cycle when out_ready_i=1 and no slots are held.
REQ-031 SHALL drive in_ready_o = (in-flight count + FIFO count) < DEPTH, using registered counts; a pop in the same cycle does not raise in_ready_o.
REQ-032 SHALL pop one FIFO entry per edge where out_valid_o=1 and out_ready_i=1.
REQ-033 SHALL hold result_o, invalid_o and illegal_o stable while out_valid_o=1 and out_ready_i=0.
REQ-034 SHALL support a simultaneous pipeline write and FIFO pop; FIFO pointers wrap modulo DEPTH.
REQ-035 SHALL never overflow the FIFO; the credit rule in REQ-031 guarantees this.
REQ-036 SHALL on flush_i=1 clear all pipeline valids, FIFO pointers and counts at that edge; flush overrides a same-cycle accept and pop.
REQ-037 SHALL drive busy_o=1 whenever any pipeline valid bit is set or the FIFO is non-empty.

Reset
REQ-038 SHALL on Reset=0 asynchronously clear pipeline valids, FIFO pointers and counters.
REQ-039 SHALL during reset drive in_ready_o=0, out_valid_o=0, busy_o=0, result_o=0, invalid_o=0 and illegal_o=0.
REQ-040 SHALL drive in_ready_o=1 from the first cycle after Reset deasserts.
REQ-041 SHALL discard an operation in flight when Reset asserts mid-operation, producing no result afterwards.

Verification
REQ-042 SHALL check FLT: opa=0xBF800000, opb=0x3F800000, out_ready_i=1 -> result_o=0x00000001 at accept+LATENCY, invalid_o=0.
REQ-043 SHALL check FABS/FNEG: opa=0xC0490FDB -> FABS 0x40490FDB, then FNEG 0x40490FDB.
REQ-044 SHALL check zeros and NaN: FEQ 0x00000000 vs 0x80000000 -> 1; FLT 0x7FC00000 vs 0x3F800000 -> 0 with invalid_o=1; FMAX 0x7FC00000 vs 0x3F800000 -> 0x3F800000.
REQ-045 SHALL check backpressure: out_ready_i=0, issue 6 back-to-back -> exactly 4 accepted, in_ready_o=0; then out_ready_i=1 -> 4 results in order, in_ready_o=1 the cycle after the first pop.
REQ-046 SHALL check flush and illegal opcode: flush with 3 queued -> out_valid_o=0, busy_o=0 next cycle, a same-cycle accept dropped; op 000000 -> result 0 with illegal_o=1.
